// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer kinds, response codes, size/burst
// typedefs and the default-slave state encoding.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [2:0] hsize_t;
    typedef logic [2:0] hburst_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for unmapped transfers plus a
// saturating decode-error counter.
// Ports: hclk/hreset, start (unmapped NONSEQ/SEQ accepted this cycle),
//        hready/hresp (data-phase response), err_count.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    start,
    output logic                    hready,
    output logic                    hresp,
    output logic [ERRCNT_WIDTH-1:0] err_count
);

    dstate_t                 state_q, state_d;
    logic [ERRCNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        unique case (state_q)
            D_IDLE: begin
                if (start) state_d = D_ERR1;
            end
            D_ERR1: begin
                hready  = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = D_ERR2;
            end
            D_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = start ? D_ERR1 : D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
        // Count each fresh entry into the first error cycle.
        if (state_d == D_ERR1 && state_q != D_ERR1 && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= D_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign err_count = cnt_q;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master, NUM_SLAVES-port AHB-Lite interconnect: address
// decode to HSELx, registered data-phase select, response mux and an
// internal default slave for unmapped space.
// Ports: m_* master side, s_* slave side (windows, selects, broadcast
//        copies, per-slave responses), err_count decode-error count.
module ahb_lite_interconnect
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLAVES   = 4,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [ADDR_WIDTH-1:0]            m_haddr,
    input  logic [1:0]                       m_htrans,
    input  logic                             m_hwrite,
    input  logic [2:0]                       m_hsize,
    input  logic [2:0]                       m_hburst,
    input  logic [3:0]                       m_hprot,
    input  logic                             m_hmastlock,
    input  logic [DATA_WIDTH-1:0]            m_hwdata,
    output logic [DATA_WIDTH-1:0]            m_hrdata,
    output logic                             m_hready,
    output logic                             m_hresp,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_base_addr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_last_addr,
    output logic [NUM_SLAVES-1:0]            s_hsel,
    output logic [ADDR_WIDTH-1:0]            s_haddr,
    output logic [1:0]                       s_htrans,
    output logic                             s_hwrite,
    output logic [2:0]                       s_hsize,
    output logic [2:0]                       s_hburst,
    output logic [3:0]                       s_hprot,
    output logic                             s_hmastlock,
    output logic [DATA_WIDTH-1:0]            s_hwdata,
    output logic                             s_hready_broadcast,
    input  logic [NUM_SLAVES-1:0]            s_hready,
    input  logic [NUM_SLAVES-1:0]            s_hresp,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata,
    output logic [ERRCNT_WIDTH-1:0]          err_count
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    htrans_t          trans;
    logic             trans_act;
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] dsel_idx_q, dsel_idx_d;
    logic             dsel_def_q, dsel_def_d;
    logic             dactive_q, dactive_d;
    logic             dflt_start;
    logic             dflt_hready;
    logic             dflt_hresp;

    assign trans     = htrans_t'(m_htrans);
    assign trans_act = (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);

    // Scan high to low so the lowest matching index is the one kept.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        s_hsel  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (m_haddr >= s_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                m_haddr <= s_last_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                dec_hit   = 1'b1;
                dec_idx   = IDX_W'(i);
                s_hsel    = '0;
                s_hsel[i] = 1'b1;
            end
        end
    end

    // Data-phase target advances only when the current one completes.
    always_comb begin
        dsel_idx_d = dsel_idx_q;
        dsel_def_d = dsel_def_q;
        dactive_d  = dactive_q;
        if (m_hready) begin
            dsel_idx_d = dec_idx;
            dsel_def_d = !dec_hit;
            dactive_d  = trans_act;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            dsel_idx_q <= '0;
            dsel_def_q <= 1'b1;
            dactive_q  <= 1'b0;
        end else begin
            dsel_idx_q <= dsel_idx_d;
            dsel_def_q <= dsel_def_d;
            dactive_q  <= dactive_d;
        end
    end

    assign dflt_start = m_hready && !dec_hit && trans_act;

    ahb_default_slave #(
        .ERRCNT_WIDTH (ERRCNT_WIDTH)
    ) u_dflt (
        .hclk      (hclk),
        .hreset    (hreset),
        .start     (dflt_start),
        .hready    (dflt_hready),
        .hresp     (dflt_hresp),
        .err_count (err_count)
    );

    always_comb begin
        m_hready = 1'b1;
        m_hresp  = HRESP_OKAY;
        m_hrdata = '0;
        if (dsel_def_q) begin
            if (dactive_q) begin
                m_hready = dflt_hready;
                m_hresp  = dflt_hresp;
            end
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_idx_q == IDX_W'(i)) begin
                    m_hready = s_hready[i];
                    m_hresp  = s_hresp[i];
                    m_hrdata = s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign s_haddr            = m_haddr;
    assign s_htrans           = m_htrans;
    assign s_hwrite           = m_hwrite;
    assign s_hsize            = m_hsize;
    assign s_hburst           = m_hburst;
    assign s_hprot            = m_hprot;
    assign s_hmastlock        = m_hmastlock;
    assign s_hwdata           = m_hwdata;
    assign s_hready_broadcast = m_hready;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect: stimulus pushes expected
// per-cycle responses, a negedge monitor pops and compares them.
module tb_ahb_lite_interconnect;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int EW = 8;

    logic           clk = 1'b0;
    logic           hreset;
    logic [AW-1:0]  m_haddr;
    logic [1:0]     m_htrans;
    logic           m_hwrite;
    logic [2:0]     m_hsize;
    logic [2:0]     m_hburst;
    logic [3:0]     m_hprot;
    logic           m_hmastlock;
    logic [DW-1:0]  m_hwdata;
    logic [DW-1:0]  m_hrdata;
    logic           m_hready;
    logic           m_hresp;
    logic [NS*AW-1:0] s_base_addr;
    logic [NS*AW-1:0] s_last_addr;
    logic [NS-1:0]  s_hsel;
    logic [AW-1:0]  s_haddr;
    logic [1:0]     s_htrans;
    logic           s_hwrite;
    logic [2:0]     s_hsize;
    logic [2:0]     s_hburst;
    logic [3:0]     s_hprot;
    logic           s_hmastlock;
    logic [DW-1:0]  s_hwdata;
    logic           s_hready_broadcast;
    logic [NS-1:0]  s_hready;
    logic [NS-1:0]  s_hresp;
    logic [NS*DW-1:0] s_hrdata;
    logic [EW-1:0]  err_count;

    always #5 clk = ~clk;

    ahb_lite_interconnect #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .NUM_SLAVES   (NS),
        .ERRCNT_WIDTH (EW)
    ) dut (
        .hclk               (clk),
        .hreset             (hreset),
        .m_haddr            (m_haddr),
        .m_htrans           (m_htrans),
        .m_hwrite           (m_hwrite),
        .m_hsize            (m_hsize),
        .m_hburst           (m_hburst),
        .m_hprot            (m_hprot),
        .m_hmastlock        (m_hmastlock),
        .m_hwdata           (m_hwdata),
        .m_hrdata           (m_hrdata),
        .m_hready           (m_hready),
        .m_hresp            (m_hresp),
        .s_base_addr        (s_base_addr),
        .s_last_addr        (s_last_addr),
        .s_hsel             (s_hsel),
        .s_haddr            (s_haddr),
        .s_htrans           (s_htrans),
        .s_hwrite           (s_hwrite),
        .s_hsize            (s_hsize),
        .s_hburst           (s_hburst),
        .s_hprot            (s_hprot),
        .s_hmastlock        (s_hmastlock),
        .s_hwdata           (s_hwdata),
        .s_hready_broadcast (s_hready_broadcast),
        .s_hready           (s_hready),
        .s_hresp            (s_hresp),
        .s_hrdata           (s_hrdata),
        .err_count          (err_count)
    );

    typedef struct {
        string       name;
        logic [3:0]  hsel;
        logic        hready;
        logic        hresp;
        logic [31:0] rdata;
        logic [7:0]  err;
        logic [31:0] haddr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [31:0] a);
        m_htrans = t;
        m_haddr  = a;
    endtask

    task automatic expect_now(input string n, input logic [3:0] hs,
                              input logic hr, input logic rs,
                              input logic [31:0] rd, input logic [7:0] ec);
        exp_t e;
        e.name   = n;
        e.hsel   = hs;
        e.hready = hr;
        e.hresp  = rs;
        e.rdata  = rd;
        e.err    = ec;
        e.haddr  = m_haddr;
        q.push_back(e);
    endtask

    task automatic set_win(input int i, input logic [31:0] b,
                           input logic [31:0] l);
        s_base_addr[i*AW +: AW] = b;
        s_last_addr[i*AW +: AW] = l;
    endtask

    // Monitor: compares whatever the stimulus has queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (s_hsel !== e.hsel || m_hready !== e.hready ||
                m_hresp !== e.hresp || m_hrdata !== e.rdata ||
                err_count !== e.err || s_hready_broadcast !== e.hready ||
                s_haddr !== e.haddr) begin
                n_bad++;
                $display("FAIL %s: got hsel=%b hready=%b hresp=%b rdata=%h err=%h bcast=%b haddr=%h; want hsel=%b hready=%b hresp=%b rdata=%h err=%h haddr=%h",
                         e.name, s_hsel, m_hready, m_hresp, m_hrdata,
                         err_count, s_hready_broadcast, s_haddr, e.hsel,
                         e.hready, e.hresp, e.rdata, e.err, e.haddr);
            end
        end
    end

    initial begin
        hreset      = 1'b1;
        m_hwrite    = 1'b0;
        m_hsize     = 3'd2;
        m_hburst    = 3'd0;
        m_hprot     = 4'h3;
        m_hmastlock = 1'b0;
        m_hwdata    = 32'h5A5A_0001;
        s_base_addr = '0;
        s_last_addr = '0;
        set_win(0, 32'h0000_0000, 32'h0000_FFFF);
        set_win(1, 32'h1000_0000, 32'h1000_0FFF);
        set_win(2, 32'h2000_0000, 32'h2000_0FFF);
        set_win(3, 32'h3000_0000, 32'h3000_0FFF);
        s_hready = 4'hF;
        s_hresp  = 4'h0;
        s_hrdata = {32'h3333_3333, 32'h2222_2222,
                    32'hCAFE_F00D, 32'h0000_AAAA};
        drive(IDLE, 32'h8000_0000);

        step();
        hreset = 1'b0;
        drive(NONSEQ, 32'h1000_0004);
        expect_now("reset", 4'b0010, 1, 0, 32'h0, 8'd0);

        step();
        drive(IDLE, 32'h0000_0000);
        expect_now("rd_s1", 4'b0001, 1, 0, 32'hCAFE_F00D, 8'd0);

        step();
        drive(NONSEQ, 32'h0000_0010);
        expect_now("s0_addr", 4'b0001, 1, 0, 32'h0000_AAAA, 8'd0);

        step();
        s_hready[0] = 1'b0;
        drive(NONSEQ, 32'h2000_0000);
        expect_now("stall1", 4'b0100, 0, 0, 32'h0000_AAAA, 8'd0);
        step();
        expect_now("stall2", 4'b0100, 0, 0, 32'h0000_AAAA, 8'd0);
        step();
        expect_now("stall3", 4'b0100, 0, 0, 32'h0000_AAAA, 8'd0);
        step();
        s_hready[0] = 1'b1;
        expect_now("stall_end", 4'b0100, 1, 0, 32'h0000_AAAA, 8'd0);

        step();
        drive(IDLE, 32'h0000_0000);
        expect_now("rd_s2", 4'b0001, 1, 0, 32'h2222_2222, 8'd0);

        step();
        drive(NONSEQ, 32'h8000_0000);
        expect_now("unm_addr", 4'b0000, 1, 0, 32'h0000_AAAA, 8'd0);
        step();
        drive(IDLE, 32'h8000_0000);
        expect_now("err1", 4'b0000, 0, 1, 32'h0, 8'd1);
        step();
        expect_now("err2", 4'b0000, 1, 1, 32'h0, 8'd1);
        step();
        expect_now("idle_unm", 4'b0000, 1, 0, 32'h0, 8'd1);
        step();
        expect_now("idle_unm2", 4'b0000, 1, 0, 32'h0, 8'd1);

        step();
        drive(NONSEQ, 32'h8000_0000);
        expect_now("b2b_addr", 4'b0000, 1, 0, 32'h0, 8'd1);
        step();
        drive(NONSEQ, 32'h8000_0004);
        expect_now("b2b_err1a", 4'b0000, 0, 1, 32'h0, 8'd2);
        step();
        expect_now("b2b_err2a", 4'b0000, 1, 1, 32'h0, 8'd2);
        step();
        drive(IDLE, 32'h8000_0004);
        expect_now("b2b_err1b", 4'b0000, 0, 1, 32'h0, 8'd3);
        step();
        expect_now("b2b_err2b", 4'b0000, 1, 1, 32'h0, 8'd3);
        step();
        expect_now("b2b_done", 4'b0000, 1, 0, 32'h0, 8'd3);

        set_win(3, 32'h1000_0000, 32'h1000_FFFF);
        step();
        drive(IDLE, 32'h1000_0000);
        expect_now("overlap", 4'b0010, 1, 0, 32'h0, 8'd3);
        step();
        drive(IDLE, 32'h1000_1000);
        expect_now("s3_only", 4'b1000, 1, 0, 32'hCAFE_F00D, 8'd3);
        step();
        drive(IDLE, 32'h0000_FFFF);
        expect_now("s0_last", 4'b0001, 1, 0, 32'h3333_3333, 8'd3);
        step();
        drive(IDLE, 32'h0001_0000);
        expect_now("s0_past", 4'b0000, 1, 0, 32'h0000_AAAA, 8'd3);

        step();
        drive(NONSEQ, 32'h8000_0000);
        expect_now("sat_start", 4'b0000, 1, 0, 32'h0, 8'd3);
        repeat (600) step();
        drive(IDLE, 32'h8000_0000);
        repeat (2) step();
        step();
        expect_now("sat", 4'b0000, 1, 0, 32'h0, 8'hFF);

        step();
        drive(NONSEQ, 32'h8000_0000);
        expect_now("sat_addr", 4'b0000, 1, 0, 32'h0, 8'hFF);
        step();
        hreset = 1'b1;
        drive(IDLE, 32'h8000_0000);
        expect_now("sat_hold", 4'b0000, 0, 1, 32'h0, 8'hFF);
        step();
        hreset = 1'b0;
        expect_now("rst_mid", 4'b0000, 1, 0, 32'h0, 8'd0);
        step();
        expect_now("post_rst", 4'b0000, 1, 0, 32'h0, 8'd0);

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
